// File: rtl/lsu_handshake_pkg.sv
// ----------------------------------------------------------------------------
// lsu_handshake_pkg
// Shared definitions for the load/store unit and its lane-alignment helper:
//   - lsu_state_t : control FSM states
//   - F3_*        : RISC-V load/store func3 encodings
//   - CAUSE_*     : mcause codes reported on out_cause
//   - size_m1()   : access size minus one (byte count - 1) from func3[1:0]
// ----------------------------------------------------------------------------
package lsu_handshake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    // Access size minus one: 0, 1, 3 or 7. Doubles as the low-address
    // alignment mask for the access.
    function automatic logic [2:0] size_m1(input logic [1:0] sz);
        return 3'((4'd1 << sz) - 4'd1);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for a DATA_W-wide memory port.
//   off        in  byte offset of the access within the data word
//   func3      in  RISC-V load/store func3 (size in [1:0], unsigned in [2])
//   wdata      in  right-justified store data
//   rdata      in  full-width read data from memory
//   wstrb      out byte strobes: size mask shifted to the lane
//   wdata_lane out store data shifted onto its byte lane
//   rdata_ext  out read data shifted down and sign/zero extended
// ----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_handshake_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] wdata_lane,
    output logic [DATA_W-1:0] rdata_ext
);

    logic [7:0]        mask8;
    logic [DATA_W-1:0] rdata_sh;

    always_comb begin
        case (func3[1:0])
            2'd0:    mask8 = 8'h01;
            2'd1:    mask8 = 8'h03;
            2'd2:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
    end

    assign wstrb      = STRB_W'(mask8) << off;
    assign wdata_lane = wdata << {off, 3'b000};
    assign rdata_sh   = rdata >> {off, 3'b000};

    always_comb begin
        rdata_ext = rdata_sh;
        case (func3)
            F3_LB:   rdata_ext = DATA_W'($signed(rdata_sh[7:0]));
            F3_LH:   rdata_ext = DATA_W'($signed(rdata_sh[15:0]));
            F3_LW:   rdata_ext = DATA_W'($signed(rdata_sh[31:0]));
            F3_LBU:  rdata_ext = DATA_W'(rdata_sh[7:0]);
            F3_LHU:  rdata_ext = DATA_W'(rdata_sh[15:0]);
            F3_LWU:  rdata_ext = DATA_W'(rdata_sh[31:0]);
            F3_LD:   rdata_ext = rdata_sh;
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/lsu_handshake.sv
// ----------------------------------------------------------------------------
// lsu_handshake
// Multi-cycle load/store unit: accepts one op from execute (in_*), issues an
// aligned request with strobes on the memory port (mem_req_*), waits for the
// response (mem_resp_*) with a timeout, and returns the extended result to
// writeback (out_*). Asynchronous active-low reset on rst.
//   in_valid/in_ready      op handshake from execute
//   in_addr/in_wdata       effective address, right-justified store data
//   in_func3/in_store      RISC-V func3 and load/store select
//   out_valid/out_ready    result handshake to writeback
//   out_rdata              extended load data, 0 for stores and faults
//   out_err/out_cause      fault flag and mcause code
//   mem_req_*              request port (addr aligned to DATA_W/8)
//   mem_resp_*             response port
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned ops trap with
// cause 4/6 instead of being force-aligned.
// ----------------------------------------------------------------------------
module lsu_handshake
    import lsu_handshake_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 32,
    parameter  int TIMEOUT = 255,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [2:0]        in_func3,
    input  logic              in_store,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic              out_err,
    output logic [3:0]        out_cause,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [STRB_W-1:0] mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata,
    input  logic              mem_resp_err
);

    localparam int OFF_W = $clog2(STRB_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [2:0]        func3_reg, func3_next;
    logic              store_reg, store_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [3:0]        cause_reg, cause_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    logic              illegal_op;
    logic [OFF_W-1:0]  off_aligned;
    logic [STRB_W-1:0] lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic [3:0]        fault_cause;

    // Sizes wider than the port (ld/lwu on 32-bit) and 111 are illegal;
    // stores have no unsigned variants.
    assign illegal_op = (in_store && in_func3[2]) || (in_func3 == 3'b111) ||
                        ((DATA_W == 32) && ((in_func3 == F3_LD) || (in_func3 == F3_LWU)));

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_op;
    assign misalign_op = |(in_addr[OFF_W-1:0] & OFF_W'(size_m1(in_func3[1:0])));
`endif

    // Clearing the low offset bits to size alignment keeps every access
    // inside one data word. With the trap enabled misaligned ops never reach
    // REQ, so this masking is a no-op there.
    assign off_aligned = addr_reg[OFF_W-1:0] & ~OFF_W'(size_m1(func3_reg[1:0]));
    assign fault_cause = store_reg ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .off        (off_aligned),
        .func3      (func3_reg),
        .wdata      (wdata_reg),
        .rdata      (mem_resp_rdata),
        .wstrb      (lane_wstrb),
        .wdata_lane (lane_wdata),
        .rdata_ext  (lane_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            func3_reg <= '0;
            store_reg <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
            cause_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            func3_reg <= func3_next;
            store_reg <= store_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
            cause_reg <= cause_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        func3_next = func3_reg;
        store_next = store_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        cause_next = cause_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_next  = in_addr;
                    wdata_next = in_wdata;
                    func3_next = in_func3;
                    store_next = in_store;
                    rdata_next = '0;
                    err_next   = 1'b0;
                    cause_next = '0;
                    if (illegal_op) begin
                        err_next   = 1'b1;
                        cause_next = CAUSE_ILLEGAL;
                        state_next = ST_DONE;
                    end
`ifdef LSU_MISALIGN_TRAP_EN
                    else if (misalign_op) begin
                        err_next   = 1'b1;
                        cause_next = in_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                        state_next = ST_DONE;
                    end
`endif
                    else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    cnt_next   = '0;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // A response in the timeout cycle still wins.
                if (mem_resp_valid) begin
                    if (mem_resp_err) begin
                        err_next   = 1'b1;
                        cause_next = fault_cause;
                    end else begin
                        rdata_next = store_reg ? '0 : lane_rdata;
                    end
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    cause_next = fault_cause;
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are qualified by state so everything reads 0 outside the
    // phase that owns it, including immediately after an async reset.
    assign in_ready      = (state_reg == ST_IDLE);
    assign mem_req_valid = (state_reg == ST_REQ);
    assign mem_req_addr  = mem_req_valid ? {addr_reg[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
    assign mem_req_wen   = mem_req_valid & store_reg;
    assign mem_req_wdata = mem_req_valid ? lane_wdata : '0;
    assign mem_req_wstrb = mem_req_valid ? lane_wstrb : '0;
    assign out_valid     = (state_reg == ST_DONE);
    assign out_rdata     = out_valid ? rdata_reg : '0;
    assign out_err       = out_valid & err_reg;
    assign out_cause     = out_valid ? cause_reg : '0;

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised multi-cycle load/store unit; successor to the single-cycle execute-stage memory path.
- Takes one memory op from the execute stage over a valid/ready handshake and issues an aligned request with byte strobes on a request/response memory port.
- Aligns and sign- or zero-extends returned data and hands the result to writeback over a second valid/ready handshake.
- Generalised in data width (32/64), with response timeout and error reporting.

Parameters:
- DATA_W, 32, data path width; legal values are 32 and 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum cycles to wait for mem_resp_valid before declaring a bus error. Must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- in_valid  in  1  op valid from execute
- in_ready  out  1  unit can accept an op
- in_addr  in  ADDR_W  effective address (ALU result)
- in_wdata  in  DATA_W  store data (rs2), right-justified
- in_func3  in  3  RISC-V load/store func3
- in_store  in  1  1 = store, 0 = load
- out_valid  out  1  result valid to writeback
- out_ready  in  1  writeback accepts
- out_rdata  out  DATA_W  extended load data; 0 for stores
- out_err  out  1  op faulted
- out_cause  out  4  mcause code when out_err=1, else 0
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  address aligned to DATA_W/8
- mem_req_wen  out  1  write request
- mem_req_wdata  out  DATA_W  store data shifted to byte lane
- mem_req_wstrb  out  DATA_W/8  byte strobes
- mem_resp_valid  in  1  response valid
- mem_resp_rdata  in  DATA_W  full-width read data
- mem_resp_err  in  1  bus error

Behaviour:
- FSM states: IDLE, REQ, RESP, DONE. All regs clear asynchronously when rst=0.
- Reset values: state=IDLE, all outputs 0 except in_ready=1.
- IDLE
  - in_ready=1.
  - On in_valid: latch addr, wdata, func3, store.
  - Legal op: go to REQ.
  - Illegal func3 (any of 011/110/111 when DATA_W=32, 111 when DATA_W=64, or store with func3[2]=1): go to DONE with out_err=1, out_cause=2, no memory request.
- REQ
  - mem_req_valid=1; request fields held stable until mem_req_ready.
  - Handshake cycle: go to RESP and clear the timeout counter.
- RESP
  - Counter increments each cycle.
  - On mem_resp_valid: capture data. If mem_resp_err=1, set out_err=1 with out_cause=5 (load) or 7 (store). Go to DONE.
  - If the counter reaches TIMEOUT first: go to DONE with out_err=1, cause 5/7.
  - If mem_resp_valid and timeout occur in the same cycle, the response wins.
- DONE
  - out_valid=1; out_* held until out_ready, then go to IDLE.
  - Zero-bubble back-to-back ops are not required; in_ready returns the cycle after the out handshake.
- Byte lane: off = addr[log2(DATA_W/8)-1:0].
  - Size from func3[1:0]: 1, 2, 4 or 8 bytes.
  - wstrb = size mask << off.
  - wdata = in_wdata << (8*off).
  - Load data = rdata >> (8*off), then extended by func3: 000/001/010 sign-extend, 100/101/110 zero-extend, 011 full width.
- Misalignment: any access where off is not a multiple of size.
  - Without the optional feature: the low address bits are cleared to size alignment before lane computation, so the access never crosses a word.
- Memory responses arriving outside RESP are ignored.
- Asynchronous reset mid-transaction drops mem_req_valid and out_valid immediately; no replay.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned legal op is detected in IDLE. No memory request is issued; go to DONE with out_err=1 and out_cause=4 (load) or 6 (store).
- Undefined: misaligned addresses are force-aligned as described above; out_cause never takes 4 or 6.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - func3 constants: LB, LH, LW, LD, LBU, LHU, LWU.
  - mcause constants: ILLEGAL=2, LD_MISALIGN=4, LD_FAULT=5, ST_MISALIGN=6, ST_FAULT=7.
- One natural sub-module: lsu_lane_align. Purely combinational; computes wstrb, shifted wdata and the extended load result from off, func3 and raw data. Reusable by a future cache.

Test Plan:
- Aligned store: DATA_W=32, sw at addr 0x80000004, wdata 0xDEADBEEF, mem ready immediately -> mem_req_addr 0x80000004, wstrb 4'b1111, out_valid with out_err=0 after the response.
- Byte loads: lb at 0x80000003, resp 0x80FF1234 -> out_rdata 0xFFFFFF80. Same op as lbu -> 0x00000080.
- Byte-lane store: sh at 0x80000002, wdata 0x0000ABCD -> wstrb 4'b1100, wdata 0xABCD0000.
- Timeout and error: TIMEOUT=4 with mem_resp_valid never asserted -> out_err=1, cause 5, exactly 4 cycles after entering RESP. Separately, mem_resp_err=1 on a store -> cause 7.
- Stalls and misalignment: mem_req_ready low for 3 cycles, then out_ready low for 2 cycles -> request and out fields held stable, in_ready=0 throughout. Then lw at 0x80000001 -> with LSU_MISALIGN_TRAP_EN, cause 4 and no mem_req_valid; without it, mem_req_addr 0x80000000 and wstrb 4'b1111.
- Reset mid-op: rst low while in RESP -> all outputs 0 and in_ready=1 immediately; a stale mem_resp_valid afterwards produces no out_valid. With DATA_W=64, ld at 0x8 with resp 0x0123456789ABCDEF -> out_rdata 0x0123456789ABCDEF.
